// File: rtl/snake_score_ctrl.sv
// ---------------------------------------------------------------------------
// snake_score_ctrl
//
// Game-state and score controller for the snake video pipeline. It steps
// through IDLE -> PLAY -> OVER -> PLAY and keeps a two-digit BCD score and
// a high score for the text overlay. During OVER it counts frame ticks so
// that a new game can only start after a hold period.
//
// Parameters:
//   HOLD_FRAMES  frame ticks spent in OVER before a start press is accepted
//                (1..255)
//
// Ports:
//   clk       in   system/pixel clock, rising edge
//   reset     in   synchronous active-high reset
//   tick      in   one-cycle pulse per video frame
//   start     in   one-cycle debounced start-button pulse
//   eat       in   one-cycle pulse, snake head reached food
//   collide   in   one-cycle pulse, snake hit a wall or itself
//   score1    out  BCD tens digit of the current score
//   score0    out  BCD units digit of the current score
//   high1     out  BCD tens digit of the high score
//   high0     out  BCD units digit of the high score
//   g_over    out  high while in OVER (selects the game-over text)
//   game_run  out  high only in PLAY (enables snake movement)
//   new_high  out  the last finished game raised the high score
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module snake_score_ctrl #(
  parameter int HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       eat,
  input  logic       collide,
  output logic [3:0] score1,
  output logic [3:0] score0,
  output logic [3:0] high1,
  output logic [3:0] high0,
  output logic       g_over,
  output logic       game_run,
  output logic       new_high
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);

  state_t     r_state;
  logic [3:0] r_score1;
  logic [3:0] r_score0;
  logic [3:0] r_high1;
  logic [3:0] r_high0;
  logic [7:0] r_hold;
  logic       r_newHigh;
  logic       r_gOver;
  logic       r_gameRun;

  state_t     w_stateNext;
  logic [3:0] w_score1Next;
  logic [3:0] w_score0Next;
  logic [3:0] w_high1Next;
  logic [3:0] w_high0Next;
  logic [7:0] w_holdNext;
  logic       w_newHighNext;

  logic [3:0] w_inc1;
  logic [3:0] w_inc0;
  logic [3:0] w_final1;
  logic [3:0] w_final0;

  // BCD increment of the current score, saturating at 99. Units wrap from
  // 9 to 0 and carry into the tens digit.
  always_comb begin
    w_inc1 = r_score1;
    w_inc0 = r_score0;
    if (r_score1 == 4'd9 && r_score0 == 4'd9) begin
      w_inc1 = r_score1;
      w_inc0 = r_score0;
    end else if (r_score0 == 4'd9) begin
      w_inc0 = 4'd0;
      w_inc1 = r_score1 + 4'd1;
    end else begin
      w_inc0 = r_score0 + 4'd1;
    end
  end

  // Score as it stands after this cycle's eat. A collide in the same cycle
  // must see this value, so the point is counted before the game ends.
  assign w_final1 = eat ? w_inc1 : r_score1;
  assign w_final0 = eat ? w_inc0 : r_score0;

  // Next-state and next-value logic. Everything holds unless the current
  // state reacts to an event; events that a state does not list are ignored.
  always_comb begin
    w_stateNext   = r_state;
    w_score1Next  = r_score1;
    w_score0Next  = r_score0;
    w_high1Next   = r_high1;
    w_high0Next   = r_high0;
    w_holdNext    = r_hold;
    w_newHighNext = r_newHigh;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext   = PLAY;
          w_score1Next  = 4'd0;
          w_score0Next  = 4'd0;
          w_newHighNext = 1'b0;
        end
      end

      PLAY: begin
        w_score1Next = w_final1;
        w_score0Next = w_final0;
        if (collide) begin
          w_stateNext = OVER;
          w_holdNext  = 8'd0;
          // With digits kept in 0..9, comparing the packed BCD byte orders
          // scores the same way as comparing their decimal values.
          if ({w_final1, w_final0} > {r_high1, r_high0}) begin
            w_high1Next   = w_final1;
            w_high0Next   = w_final0;
            w_newHighNext = 1'b1;
          end
        end
      end

      OVER: begin
        // Start is qualified by the registered counter, so a start in the
        // same cycle as the tick that completes the hold is still too early.
        if (start && r_hold == HOLD_MAX) begin
          w_stateNext   = PLAY;
          w_score1Next  = 4'd0;
          w_score0Next  = 4'd0;
          w_newHighNext = 1'b0;
          w_holdNext    = 8'd0;
        end else if (tick && r_hold < HOLD_MAX) begin
          w_holdNext = r_hold + 8'd1;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and data registers. The state-decoded outputs are registered from
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_score1  <= 4'd0;
      r_score0  <= 4'd0;
      r_high1   <= 4'd0;
      r_high0   <= 4'd0;
      r_hold    <= 8'd0;
      r_newHigh <= 1'b0;
      r_gOver   <= 1'b0;
      r_gameRun <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_score1  <= w_score1Next;
      r_score0  <= w_score0Next;
      r_high1   <= w_high1Next;
      r_high0   <= w_high0Next;
      r_hold    <= w_holdNext;
      r_newHigh <= w_newHighNext;
      r_gOver   <= (w_stateNext == OVER);
      r_gameRun <= (w_stateNext == PLAY);
    end
  end

  assign score1   = r_score1;
  assign score0   = r_score0;
  assign high1    = r_high1;
  assign high0    = r_high0;
  assign g_over   = r_gOver;
  assign game_run = r_gameRun;
  assign new_high = r_newHigh;

endmodule

// File: tb/tb_snake_score_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_score_ctrl
//
// Bench for snake_score_ctrl with HOLD_FRAMES = 3. A reference model keeps
// the score and high score as plain integers 0..99 and the game phase as a
// small integer; the DUT digits are compared against value/10 and value%10.
// ---------------------------------------------------------------------------
module tb_snake_score_ctrl;

  localparam int HOLD = 3;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic       eat;
  logic       collide;
  logic [3:0] score1;
  logic [3:0] score0;
  logic [3:0] high1;
  logic [3:0] high0;
  logic       g_over;
  logic       game_run;
  logic       new_high;

  int total;
  int bad;

  // Model: phase 0 = idle, 1 = playing, 2 = game over.
  int mPhase;
  int mScore;
  int mHigh;
  int mHold;
  bit mNewHigh;

  snake_score_ctrl #(.HOLD_FRAMES(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .eat      (eat),
    .collide  (collide),
    .score1   (score1),
    .score0   (score0),
    .high1    (high1),
    .high0    (high0),
    .g_over   (g_over),
    .game_run (game_run),
    .new_high (new_high)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit st;
    bit et;
    bit co;
    bit tk;
    int expScore;
    int expHigh;
    bit expOver;
    bit expRun;
    bit expNew;
  } vec_t;

  vec_t vecs[19];

  // Advance the model by one clock edge using the game rules directly.
  task automatic modelStep(input bit r, input bit s, input bit e,
                           input bit c, input bit t);
    if (r) begin
      mPhase = 0; mScore = 0; mHigh = 0; mHold = 0; mNewHigh = 0;
    end else begin
      case (mPhase)
        0: if (s) begin mPhase = 1; mScore = 0; mNewHigh = 0; end
        1: begin
          if (e && mScore < 99) mScore = mScore + 1;
          if (c) begin
            if (mScore > mHigh) begin mHigh = mScore; mNewHigh = 1; end
            mPhase = 2;
            mHold = 0;
          end
        end
        default: begin
          if (s && mHold == HOLD) begin
            mPhase = 1; mScore = 0; mNewHigh = 0; mHold = 0;
          end else if (t && mHold < HOLD) begin
            mHold = mHold + 1;
          end
        end
      endcase
    end
  endtask

  // Compare all DUT outputs against given expected values.
  task automatic checkOutput(input string name, input int s, input int h,
                             input bit o, input bit r, input bit n);
    int actS;
    int actH;
    actS = int'(score1) * 10 + int'(score0);
    actH = int'(high1) * 10 + int'(high0);
    total++;
    if (score1 != 4'(s / 10) || score0 != 4'(s % 10) ||
        high1 != 4'(h / 10) || high0 != 4'(h % 10) ||
        g_over !== o || game_run !== r || new_high !== n) begin
      bad++;
      $display("[TB] FAIL %s: got score=%0d%0d high=%0d%0d g_over=%0b game_run=%0b new_high=%0b, want score=%0d high=%0d g_over=%0b game_run=%0b new_high=%0b",
               name, score1, score0, high1, high0, g_over, game_run, new_high,
               s, h, o, r, n);
    end
    if (actS < 0 || actH < 0) $display("[TB] unreachable");
  endtask

  // Drive one cycle of inputs, step the model, and compare against it.
  task automatic applyStimulus(input string name, input bit r, input bit s,
                               input bit e, input bit c, input bit t);
    @(negedge clk);
    reset = r; start = s; eat = e; collide = c; tick = t;
    @(posedge clk);
    modelStep(r, s, e, c, t);
    #1;
    checkOutput(name, mScore, mHigh, (mPhase == 2), (mPhase == 1), mNewHigh);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus("model", 0, 0, 0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; start = 0; eat = 0; collide = 0; tick = 0;
    mPhase = 0; mScore = 0; mHigh = 0; mHold = 0; mNewHigh = 0;

    //          rst st et co tk  score high over run new
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0,  0, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 1, 0, 1,  1, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 1, 0, 0,  2, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 0, 0,  2, 0, 0, 1, 0};
    vecs[7]  = '{0, 0, 1, 1, 1,  3, 3, 1, 0, 1};
    vecs[8]  = '{0, 0, 1, 0, 0,  3, 3, 1, 0, 1};
    vecs[9]  = '{0, 0, 0, 1, 0,  3, 3, 1, 0, 1};
    vecs[10] = '{0, 1, 0, 0, 0,  3, 3, 1, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 1,  3, 3, 1, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 1,  3, 3, 1, 0, 1};
    vecs[13] = '{0, 1, 0, 0, 0,  3, 3, 1, 0, 1};
    vecs[14] = '{0, 1, 0, 0, 1,  3, 3, 1, 0, 1};
    vecs[15] = '{0, 1, 0, 0, 0,  0, 3, 0, 1, 0};
    vecs[16] = '{0, 0, 1, 0, 0,  1, 3, 0, 1, 0};
    vecs[17] = '{0, 0, 0, 1, 0,  1, 3, 1, 0, 0};
    vecs[18] = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      applyStimulus($sformatf("vec%0d_model", i), vecs[i].rst, vecs[i].st,
                    vecs[i].et, vecs[i].co, vecs[i].tk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expScore, vecs[i].expHigh,
                  vecs[i].expOver, vecs[i].expRun, vecs[i].expNew);
    end

    // Reset in the middle of a game.
    applyStimulus("mid_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("mid_eat", 0, 0, 1, 0, 0);
    checkOutput("mid_score3", 3, 0, 0, 1, 0);
    applyStimulus("mid_reset", 1, 0, 1, 0, 1);
    checkOutput("mid_reset", 0, 0, 0, 0, 0);

    // BCD carry and saturation, then the 99 becomes the high score.
    applyStimulus("bcd_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus("bcd_eat", 0, 0, 1, 0, 0);
    checkOutput("bcd_carry12", 12, 0, 0, 1, 0);
    for (int i = 0; i < 90; i++) applyStimulus("bcd_eat", 0, 0, 1, 0, 0);
    checkOutput("bcd_sat99", 99, 0, 0, 1, 0);
    applyStimulus("bcd_collide", 0, 0, 0, 1, 0);
    checkOutput("bcd_high99", 99, 99, 1, 0, 1);

    // Simultaneous eat and collide: high 05, score 07, then eat+collide.
    applyStimulus("sim_reset", 1, 0, 0, 0, 0);
    applyStimulus("sim_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("sim_eat", 0, 0, 1, 0, 0);
    applyStimulus("sim_collide5", 0, 0, 0, 1, 0);
    for (int i = 0; i < HOLD; i++) applyStimulus("sim_tick", 0, 0, 0, 0, 1);
    applyStimulus("sim_restart", 0, 1, 0, 0, 0);
    checkOutput("sim_restart", 0, 5, 0, 1, 0);
    for (int i = 0; i < 7; i++) applyStimulus("sim_eat", 0, 0, 1, 0, 0);
    checkOutput("sim_score07", 7, 5, 0, 1, 0);
    applyStimulus("sim_both", 0, 0, 1, 1, 1);
    checkOutput("sim_both", 8, 8, 1, 0, 1);

    // High score not beaten, then a restart clears only the score.
    for (int i = 0; i < HOLD; i++) applyStimulus("nb_tick", 0, 0, 0, 0, 1);
    applyStimulus("nb_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("nb_eat", 0, 0, 1, 0, 0);
    applyStimulus("nb_collide", 0, 0, 0, 1, 0);
    checkOutput("nb_keep_high", 3, 8, 1, 0, 0);
    for (int i = 0; i < HOLD + 2; i++) applyStimulus("nb_tick", 0, 0, 0, 0, 1);
    applyStimulus("nb_restart", 0, 1, 0, 0, 0);
    checkOutput("nb_restart", 0, 8, 0, 1, 0);

    // Hold gating is exercised again by the random phase; run it now.
    applyStimulus("rnd_reset", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) == 0));
    end
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_score_ctrl.md
# snake_score_ctrl

Game-state and score controller for the snake video pipeline. It sequences play and game-over, keeps the two-digit BCD score and high score, and drives the text overlay's score/high digits and game-over select. It consumes one-cycle event pulses from the snake/food logic and a frame tick from the VGA sync generator. All outputs are registered.

## Interface

Parameters:
- HOLD_FRAMES, default 120: number of frame ticks spent in OVER before a start press is accepted; legal range 1..255.

Ports:
- clk  input  1  system/pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle pulse per video frame.
- start  input  1  one-cycle debounced start-button pulse.
- eat  input  1  one-cycle pulse; snake head reached food.
- collide  input  1  one-cycle pulse; snake hit a wall or itself.
- score1  output  4  BCD tens digit of the current score.
- score0  output  4  BCD units digit of the current score.
- high1  output  4  BCD tens digit of the high score.
- high0  output  4  BCD units digit of the high score.
- g_over  output  1  high while in OVER; selects the game-over text.
- game_run  output  1  high only in PLAY; enables snake movement.
- new_high  output  1  high score was raised by the last finished game.

## Operation

- **States:** IDLE, PLAY, OVER. Encoding is free.
- **Reset:** state IDLE; score 00; high 00; hold counter 0; g_over 0; game_run 0; new_high 0.
- **IDLE:**
  - start → PLAY; score cleared to 00; new_high cleared.
  - eat and collide are ignored.
- **PLAY:**
  - eat increments the score in BCD: units 9 → 0 with carry into tens.
  - The score saturates at 99; eat at 99 leaves 99.
  - collide → OVER; hold counter cleared to 0.
  - start is ignored.
- **eat and collide in the same PLAY cycle:** the increment applies first, then the transition to OVER. The final score includes that point.
- **High-score update:** evaluated on the PLAY → OVER transition.
  - If the final score (after any simultaneous eat) > high, compared as an 8-bit {tens,units} BCD value, then high ← final score and new_high ← 1.
  - Otherwise high and new_high are unchanged.
- **OVER:**
  - Each tick increments the hold counter, saturating at HOLD_FRAMES.
  - start is accepted only if the registered counter already equals HOLD_FRAMES. Acceptance → PLAY; score ← 00; new_high ← 0; hold counter ← 0.
  - A start coinciding with the tick that completes the hold is ignored.
  - eat and collide are ignored.
- **Output decode:** g_over = (state == OVER); game_run = (state == PLAY).
- **High-score lifetime:** high persists across games; only reset clears it.
- **Digit range:** score and high digits never leave the range 0..9.

## Timing

- **eat:** asserted in cycle N → updated score digits visible in cycle N+1. One increment per pulse; back-to-back eat pulses each count.
- **collide:** asserted in cycle N → in cycle N+1, g_over = 1, game_run = 0, and high/new_high are updated.
- **start:** accepted in cycle N → in cycle N+1, state is PLAY, game_run = 1, g_over = 0, score = 00.
- **Hold period:** the earliest accepted start in OVER falls in the cycle after the HOLD_FRAMES-th tick counted in OVER.
- **tick:**
  - Ignored outside OVER.
  - A tick in the same cycle as collide is not counted.
- **Reset:** overrides all inputs in its cycle, including mid-game and mid-hold. Outputs show reset values from the next cycle.
- **Output timing:** no combinational path from any input to any output.

## Test plan

- **Reset mid-game:** reset, then start, 3 eat pulses, then reset during PLAY → score 00, high 00, g_over 0, game_run 0 the cycle after reset.
- **BCD carry and saturation:** start, then 12 eat pulses → score1=1, score0=2 (units wraps 9 → 0 with carry). Then 90 more pulses → score holds 99.
- **Simultaneous eat and collide:** score 07, high 05; drive eat and collide in the same cycle → next cycle score 08, high 08, new_high 1, g_over 1, game_run 0.
- **High score not beaten:** high 08; play to score 03, then collide → high stays 08, new_high 0. A further start clears the score to 00 while high remains 08.
- **Hold gating (HOLD_FRAMES=3):** after collide, start after 2 ticks → ignored, stays OVER. start together with the 3rd tick → ignored. start one cycle after the 3rd tick → PLAY next cycle with score 00.
- **Ignored events:** eat/collide in IDLE and OVER, and start in PLAY → no change in state, score, or high.
